// File: rtl/hiscore_pkg.sv
// Shared types and default constants for the high-score save/load controller.
package hiscore_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        LOAD,
        UPLOAD
    } hs_state_t;

    localparam int             HS_ADDR_W     = 10;
    localparam logic [9:0]     HS_RAM_BASE   = 10'h288;
    localparam int             HS_LEN        = 4;
    localparam logic [7:0]     HS_DL_INDEX   = 8'd3;
    localparam int             HS_LOAD_DELAY = 60;

    // Index width for a table of len bytes; never below one bit.
    function automatic int hs_idx_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/hiscore_if.sv
// Work-RAM port B plus the CPU hold handshake, shared by controller and game core.
interface hiscore_if
    import hiscore_pkg::*;
#(
    parameter int ADDR_W = HS_ADDR_W
);
    logic              pause_req;
    logic              pause_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    modport master (
        output pause_req, ram_addr, ram_we, ram_wdata,
        input  pause_ack, ram_rdata
    );

    modport slave (
        input  pause_req, ram_addr, ram_we, ram_wdata,
        output pause_ack, ram_rdata
    );
endinterface

// File: rtl/hiscore_buf.sv
// Local copy of the downloaded high-score table: one write port, one async read port.
module hiscore_buf
    import hiscore_pkg::*;
#(
    parameter int LEN   = HS_LEN,
    parameter int IDX_W = hs_idx_w(HS_LEN)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    // Deliberately not reset so a core reset can re-apply the last download.
    logic [7:0] mem_q [LEN] = '{default: 8'h00};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hiscore_ctrl.sv
// Shares game work RAM between the CPU and the HPS high-score download/upload path.
module hiscore_ctrl
    import hiscore_pkg::*;
#(
    parameter int                ADDR_W     = HS_ADDR_W,
    parameter logic [ADDR_W-1:0] RAM_BASE   = HS_RAM_BASE,
    parameter int                LEN        = HS_LEN,
    parameter logic [7:0]        DL_INDEX   = HS_DL_INDEX,
    parameter int                LOAD_DELAY = HS_LOAD_DELAY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vblank,
    input  logic        ioctl_download,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [7:0]  ioctl_din,
    output logic        busy,
    hiscore_if.master   ram_bus
);

    localparam int IDX_W = hs_idx_w(LEN);
    localparam int CNT_W = $clog2(LOAD_DELAY + 1);

    hs_state_t        state_q;
    logic             pause_req_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vblank_q, upload_q;
    logic             pending_q, pending_d;
    logic             loaded_q;
    logic             rd_q, oob_q;
    logic [7:0]       din_q;
    logic             have_data_q = 1'b0;

    logic             idx_match, addr_in_tbl, cap_we, load_go, upl_rise, ack;
    logic [7:0]       buf_rdata;

    assign ack         = ram_bus.pause_ack;
    assign idx_match   = (ioctl_index == DL_INDEX);
    assign addr_in_tbl = (ioctl_addr < 25'(LEN));
    assign cap_we      = (state_q == IDLE) && ioctl_wr && idx_match && addr_in_tbl;
    assign load_go     = have_data_q && (cnt_q == CNT_W'(LOAD_DELAY))
                         && !ioctl_download && !loaded_q;
    assign upl_rise    = ioctl_upload && !upload_q && idx_match;

    hiscore_buf #(.LEN(LEN), .IDX_W(IDX_W)) u_buf (
        .clk     (clk),
        .we_i    (cap_we),
        .waddr_i (ioctl_addr[IDX_W-1:0]),
        .wdata_i (ioctl_dout),
        .raddr_i (idx_q),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (vblank && !vblank_q && (cnt_q != CNT_W'(LOAD_DELAY))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        pending_d = pending_q;
        if (upl_rise) begin
            pending_d = 1'b1;
        end else if ((state_q == WAIT_ACK) && ack && pending_q) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_we) begin
            have_data_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pause_req_q <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            vblank_q    <= 1'b0;
            upload_q    <= 1'b0;
            pending_q   <= 1'b0;
            loaded_q    <= 1'b0;
            rd_q        <= 1'b0;
            oob_q       <= 1'b0;
            din_q       <= 8'hFF;
        end else begin
            vblank_q  <= vblank;
            upload_q  <= ioctl_upload;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            // RAM data lags its address by a clock, so the upload byte lands two clocks after rd.
            rd_q      <= ioctl_rd && (state_q == UPLOAD);
            oob_q     <= !addr_in_tbl;
            if (rd_q) begin
                din_q <= oob_q ? 8'hFF : ram_bus.ram_rdata;
            end
            if (cap_we) begin
                loaded_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (pending_q || load_go) begin
                        state_q     <= WAIT_ACK;
                        pause_req_q <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack) begin
                        state_q <= pending_q ? UPLOAD : LOAD;
                        idx_q   <= '0;
                    end
                end
                LOAD: begin
                    if (ack) begin
                        if (idx_q == IDX_W'(LEN - 1)) begin
                            idx_q       <= '0;
                            loaded_q    <= 1'b1;
                            pause_req_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                UPLOAD: begin
                    if (!ioctl_upload) begin
                        pause_req_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    pause_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Write enable is gated by the live ack and by reset so no write escapes a hold drop or abort.
    assign ram_bus.ram_we    = (state_q == LOAD) && ack && !reset;
    assign ram_bus.ram_addr  = (state_q == LOAD)   ? RAM_BASE + ADDR_W'(idx_q) :
                               (state_q == UPLOAD) ? RAM_BASE + ioctl_addr[ADDR_W-1:0] :
                                                     '0;
    assign ram_bus.ram_wdata = (state_q == LOAD) ? buf_rdata : 8'h00;
    assign ram_bus.pause_req = pause_req_q;
    assign ioctl_din         = din_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_hiscore_ctrl.sv
// Directed bench for hiscore_ctrl: load, overflow, ack glitch, upload, collision, reset reload.
module tb_hiscore_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vblank = 1'b0;
    logic        dl = 1'b0;
    logic        ul = 1'b0;
    logic [7:0]  idx = 8'd0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [24:0] addr = '0;
    logic [7:0]  dout = 8'h00;
    logic [7:0]  din;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int we_no_ack = 0;
    logic [9:0] log_addr [64];
    logic [7:0] log_data [64];
    logic [7:0] mem [1024];
    int base;

    hiscore_if #(.ADDR_W(10)) bus_if ();

    hiscore_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .vblank         (vblank),
        .ioctl_download (dl),
        .ioctl_upload   (ul),
        .ioctl_index    (idx),
        .ioctl_wr       (wr),
        .ioctl_rd       (rd),
        .ioctl_addr     (addr),
        .ioctl_dout     (dout),
        .ioctl_din      (din),
        .busy           (busy),
        .ram_bus        (bus_if)
    );

    always #5 clk = ~clk;

    // Work RAM model: synchronous write, registered read.
    always @(posedge clk) begin
        if (bus_if.ram_we) mem[bus_if.ram_addr] <= bus_if.ram_wdata;
        bus_if.ram_rdata <= mem[bus_if.ram_addr];
    end

    always @(posedge clk) begin
        if (bus_if.ram_we) begin
            if (wr_cnt < 64) begin
                log_addr[wr_cnt] <= bus_if.ram_addr;
                log_data[wr_cnt] <= bus_if.ram_wdata;
            end
            wr_cnt <= wr_cnt + 1;
            if (!bus_if.pause_ack) we_no_ack <= we_no_ack + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dl_byte(input logic [7:0] ix, input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        idx = ix; addr = a; dout = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic dl_table(input logic [31:0] d);
        logic [31:0] v;
        v = d;
        @(negedge clk);
        dl = 1'b1;
        for (int i = 0; i < 4; i++) dl_byte(8'd3, 25'(i), v[31-8*i -: 8]);
        @(negedge clk);
        dl = 1'b0;
    endtask

    task automatic vb_edges(input int n);
        repeat (n) begin
            @(negedge clk); vblank = 1'b1;
            @(negedge clk); vblank = 1'b0;
        end
    endtask

    task automatic wait_req(input string tag, input int maxc);
        int k = 0;
        while (!bus_if.pause_req && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(tag, bus_if.pause_req, 1);
    endtask

    task automatic wait_writes(input string tag, input int target, input int maxc);
        int k = 0;
        while (wr_cnt < target && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(tag, wr_cnt, target);
    endtask

    task automatic check_writes(input string tag, input int b, input logic [31:0] d);
        logic [31:0] v;
        v = d;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_addr"}, log_addr[b+i], 10'h288 + 10'(i));
            check({tag, "_data"}, log_data[b+i], v[31-8*i -: 8]);
        end
    endtask

    // Called at a negedge while in UPLOAD; checks latency then value.
    task automatic upload_rd(input string tag, input logic [24:0] a,
                             input logic [7:0] prev, input logic [7:0] exp);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check({tag, "_early"}, din, prev);
        @(negedge clk);
        check(tag, din, exp);
    endtask

    initial begin
        bus_if.pause_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pause_req", bus_if.pause_req, 0);
        check("rst_ram_we", bus_if.ram_we, 0);
        check("rst_ram_addr", bus_if.ram_addr, 0);
        check("rst_ram_wdata", bus_if.ram_wdata, 0);
        check("rst_din", din, 8'hFF);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Overflow download plus a foreign-index write, then the 60-edge delay.
        @(negedge clk);
        dl = 1'b1;
        dl_byte(8'd3, 25'd0, 8'h12);
        dl_byte(8'd3, 25'd1, 8'h34);
        dl_byte(8'd3, 25'd2, 8'h56);
        dl_byte(8'd3, 25'd3, 8'h78);
        dl_byte(8'd3, 25'd4, 8'h9A);
        dl_byte(8'd3, 25'd5, 8'hBC);
        dl_byte(8'd2, 25'd0, 8'hEE);
        @(negedge clk);
        dl = 1'b0;
        vb_edges(59);
        repeat (3) @(negedge clk);
        check("early_no_req", bus_if.pause_req, 0);
        check("early_not_busy", busy, 0);
        vb_edges(1);
        wait_req("load1_req", 10);
        check("load1_wait_we", bus_if.ram_we, 0);
        repeat (2) @(negedge clk);
        bus_if.pause_ack = 1'b1;
        wait_writes("load1_cnt", 4, 20);
        check("load1_req_low", bus_if.pause_req, 0);
        @(negedge clk);
        check("load1_cnt_hold", wr_cnt, 4);
        check_writes("load1", 0, 32'h12345678);
        bus_if.pause_ack = 1'b0;

        // Ack drops for three clocks after the second write.
        base = wr_cnt;
        dl_table(32'hAABBCCDD);
        wait_req("glitch_req", 10);
        repeat (2) @(negedge clk);
        bus_if.pause_ack = 1'b1;
        wait_writes("glitch_half", base + 2, 20);
        bus_if.pause_ack = 1'b0;
        @(negedge clk);
        check("glitch_we_low", bus_if.ram_we, 0);
        check("glitch_addr_frozen", bus_if.ram_addr, 10'h28A);
        repeat (2) @(negedge clk);
        bus_if.pause_ack = 1'b1;
        wait_writes("glitch_cnt", base + 4, 20);
        check("glitch_req_low", bus_if.pause_req, 0);
        check_writes("glitch", base, 32'hAABBCCDD);
        bus_if.pause_ack = 1'b0;

        // Upload of AA,BB,CC,DD then two out-of-table reads.
        base = wr_cnt;
        @(negedge clk);
        idx = 8'd3; ul = 1'b1;
        wait_req("upl_req", 10);
        bus_if.pause_ack = 1'b1;
        check("upl_busy", busy, 1);
        @(negedge clk);
        upload_rd("upl_rd0", 25'd0, 8'hFF, 8'hAA);
        upload_rd("upl_rd1", 25'd1, 8'hAA, 8'hBB);
        upload_rd("upl_rd2", 25'd2, 8'hBB, 8'hCC);
        upload_rd("upl_rd3", 25'd3, 8'hCC, 8'hDD);
        upload_rd("upl_rd4", 25'd4, 8'hDD, 8'hFF);
        upload_rd("upl_rd5", 25'd5, 8'hFF, 8'hFF);
        ul = 1'b0;
        @(negedge clk);
        check("upl_end_req", bus_if.pause_req, 0);
        check("upl_end_busy", busy, 0);
        check("upl_no_write", wr_cnt, base);

        // Upload requested mid-load: load finishes first, then upload.
        base = wr_cnt;
        dl_table(32'h11223344);
        wait_req("coll_req", 10);
        wait_writes("coll_first", base + 1, 20);
        ul = 1'b1;
        wait_writes("coll_cnt", base + 4, 20);
        check("coll_gap_req", bus_if.pause_req, 0);
        @(negedge clk);
        check("coll_upl_req", bus_if.pause_req, 1);
        @(negedge clk);
        upload_rd("coll_rd0", 25'd0, 8'hFF, 8'h11);
        check_writes("coll", base, 32'h11223344);
        ul = 1'b0;
        @(negedge clk);

        // Upload and load eligible in the same clock: upload wins.
        base = wr_cnt;
        @(negedge clk);
        dl = 1'b1;
        for (int i = 0; i < 4; i++) dl_byte(8'd3, 25'(i), 8'h55 + 8'(i * 8'h11));
        @(negedge clk);
        ul = 1'b1;
        @(negedge clk);
        dl = 1'b0;
        @(negedge clk);
        check("prio_req", bus_if.pause_req, 1);
        @(negedge clk);
        check("prio_no_load", wr_cnt, base);
        upload_rd("prio_rd1", 25'd1, 8'h11, 8'h22);
        ul = 1'b0;
        wait_writes("prio_cnt", base + 4, 20);
        check_writes("prio", base, 32'h55667788);

        // Reset after two writes aborts, then the retained buffer is reloaded.
        base = wr_cnt;
        dl_table(32'hC1C2C3C4);
        wait_req("rst_req", 10);
        wait_writes("rst_half", base + 2, 20);
        reset = 1'b1;
        @(negedge clk);
        check("rst_abort_req", bus_if.pause_req, 0);
        check("rst_abort_we", bus_if.ram_we, 0);
        check("rst_abort_busy", busy, 0);
        check("rst_abort_din", din, 8'hFF);
        check("rst_abort_cnt", wr_cnt, base + 2);
        reset = 1'b0;
        base = wr_cnt;
        vb_edges(59);
        repeat (3) @(negedge clk);
        check("rst_early_no_req", bus_if.pause_req, 0);
        vb_edges(1);
        wait_req("reload_req", 10);
        wait_writes("reload_cnt", base + 4, 20);
        check_writes("reload", base, 32'hC1C2C3C4);

        @(negedge clk);
        check("total_writes", wr_cnt, 22);
        check("we_without_ack", we_no_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
